// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes and register ids.
// Imported by the decode/write-back stage and its register file.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NREGS = 15;

endpackage

// File: rtl/decode_writeback_if.sv
// Fetch/execute-facing bundle of the decode/write-back stage.
// The stage itself is the slave; the surrounding datapath is the master.
interface decode_writeback_if #(
    parameter int DATA_W = 64
);

    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              cnd;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic              wb_en;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;

    modport master (
        output icode, rA, rB, cnd, valE, valM, wb_en,
        input  srcA, srcB, dstE, dstM, valA, valB
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, wb_en,
        output srcA, srcB, dstE, dstM, valA, valB
    );

endinterface

// File: rtl/y86_regfile.sv
// 15-entry Y86-64 register file: three combinational reads, two writes.
// Id F never stores and reads as zero; port M wins a same-id collision.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        addr_a_i,
    input  logic [3:0]        addr_b_i,
    input  logic [3:0]        addr_dbg_i,
    output logic [DATA_W-1:0] data_a_o,
    output logic [DATA_W-1:0] data_b_o,
    output logic [DATA_W-1:0] data_dbg_o,
    input  logic              we_i,
    input  logic [3:0]        dst_e_i,
    input  logic [3:0]        dst_m_i,
    input  logic [DATA_W-1:0] val_e_i,
    input  logic [DATA_W-1:0] val_m_i
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    assign data_a_o   = (addr_a_i == RNONE) ? '0 : regs_q[addr_a_i];
    assign data_b_o   = (addr_b_i == RNONE) ? '0 : regs_q[addr_b_i];
    assign data_dbg_o = (addr_dbg_i == RNONE) ? '0 : regs_q[addr_dbg_i];

    // M is applied last so it overrides E on popq %rsp
    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            if (dst_e_i != RNONE) regs_d[dst_e_i] = val_e_i;
            if (dst_m_i != RNONE) regs_d[dst_m_i] = val_m_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode + write-back stage: register-id decode around the
// Y86-64 register file, with commit of valE/valM at the clock edge.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_writeback_if.slave dw,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic is_rrmov, is_irmov, is_rmmov, is_mrmov;
    logic is_op, is_call, is_ret, is_push, is_pop;
    logic [3:0] src_a, src_b, dst_e, dst_m;

    assign is_rrmov = (dw.icode == IRRMOVQ);
    assign is_irmov = (dw.icode == IIRMOVQ);
    assign is_rmmov = (dw.icode == IRMMOVQ);
    assign is_mrmov = (dw.icode == IMRMOVQ);
    assign is_op    = (dw.icode == IOPQ);
    assign is_call  = (dw.icode == ICALL);
    assign is_ret   = (dw.icode == IRET);
    assign is_push  = (dw.icode == IPUSHQ);
    assign is_pop   = (dw.icode == IPOPQ);

    always_comb begin
        src_a = RNONE;
        unique case (1'b1)
            is_rrmov | is_rmmov | is_op | is_push: src_a = dw.rA;
            is_pop | is_ret:                       src_a = RRSP;
            default:                               ;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        unique case (1'b1)
            is_rmmov | is_mrmov | is_op:         src_b = dw.rB;
            is_push | is_pop | is_call | is_ret: src_b = RRSP;
            default:                             ;
        endcase
    end

    // cmovXX shares icode 2 with rrmovq; a failed condition drops the write
    always_comb begin
        dst_e = RNONE;
        unique case (1'b1)
            is_rrmov:                            dst_e = dw.cnd ? dw.rB : RNONE;
            is_irmov | is_op:                    dst_e = dw.rB;
            is_push | is_pop | is_call | is_ret: dst_e = RRSP;
            default:                             ;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        unique case (1'b1)
            is_mrmov | is_pop: dst_m = dw.rA;
            default:           ;
        endcase
    end

    assign dw.srcA = src_a;
    assign dw.srcB = src_b;
    assign dw.dstE = dst_e;
    assign dw.dstM = dst_m;

    y86_regfile #(
        .DATA_W   (DATA_W),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_a_i   (src_a),
        .addr_b_i   (src_b),
        .addr_dbg_i (dbg_addr),
        .data_a_o   (dw.valA),
        .data_b_o   (dw.valB),
        .data_dbg_o (dbg_data),
        .we_i       (dw.wb_en),
        .dst_e_i    (dst_e),
        .dst_m_i    (dst_m),
        .val_e_i    (dw.valE),
        .val_m_i    (dw.valM)
    );

endmodule
